// File: rtl/cache_arbiter.sv
// rtl/cache_arbiter.sv - two-way round-robin arbiter for the shared physical-memory port
//
// Purpose: lets the I-cache and D-cache controllers share one physical-memory port.
// One requester is granted at a time. Its command is captured in registers and then
// driven on pmem_*. The pmem completion pulse is routed back to the granted cache only.
//
// Ports:
//   clk, reset                  clock and synchronous active-high reset
//   i_mem_read/address          I-cache line read request (the I-cache never writes)
//   i_mem_rdata/resp            read line and completion pulse returned to the I-cache
//   d_mem_read/write/address    D-cache line read or write-back request
//   d_mem_wdata                 D-cache write-back line
//   d_mem_rdata/resp            read line and completion pulse returned to the D-cache
//   pmem_read/write/address     physical-memory command, driven from registers
//   pmem_wdata                  physical-memory write line, driven from registers
//   pmem_rdata/resp             physical-memory read line and completion pulse
module cache_arbiter #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_mem_read,
  input  logic [ADDR_W-1:0] i_mem_address,
  output logic [LINE_W-1:0] i_mem_rdata,
  output logic              i_mem_resp,
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_mem_address,
  input  logic [LINE_W-1:0] d_mem_wdata,
  output logic [LINE_W-1:0] d_mem_rdata,
  output logic              d_mem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2
  } state_e;

  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              cmd_rd_q, cmd_rd_d;
  logic              cmd_wr_q, cmd_wr_d;
  logic [ADDR_W-1:0] cmd_addr_q, cmd_addr_d;
  logic [LINE_W-1:0] cmd_wdata_q, cmd_wdata_d;

  logic i_req;
  logic d_req;
  logic grant_d;
  logic grant_i;

  assign i_req = i_mem_read;
  assign d_req = d_mem_read | d_mem_write;

  // On a tie, the side that did not win last time is granted.
  assign grant_d = d_req & (~i_req | (last_grant_q == GRANT_I));
  assign grant_i = i_req & ~grant_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= GRANT_I;
      cmd_rd_q     <= 1'b0;
      cmd_wr_q     <= 1'b0;
      cmd_addr_q   <= '0;
      cmd_wdata_q  <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cmd_rd_q     <= cmd_rd_d;
      cmd_wr_q     <= cmd_wr_d;
      cmd_addr_q   <= cmd_addr_d;
      cmd_wdata_q  <= cmd_wdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cmd_rd_d     = cmd_rd_q;
    cmd_wr_d     = cmd_wr_q;
    cmd_addr_d   = cmd_addr_q;
    cmd_wdata_d  = cmd_wdata_q;
    unique case (state_q)
      IDLE: begin
        if (grant_d) begin
          // A simultaneous read and write from the D-cache is illegal; it is treated as a write.
          cmd_wr_d     = d_mem_write;
          cmd_rd_d     = d_mem_read & ~d_mem_write;
          cmd_addr_d   = d_mem_address;
          cmd_wdata_d  = d_mem_wdata;
          last_grant_d = GRANT_D;
          state_d      = SERVE_D;
        end else if (grant_i) begin
          cmd_rd_d     = 1'b1;
          cmd_wr_d     = 1'b0;
          cmd_addr_d   = i_mem_address;
          cmd_wdata_d  = '0;
          last_grant_d = GRANT_I;
          state_d      = SERVE_I;
        end
      end
      SERVE_I, SERVE_D: begin
        // The command stays frozen until memory completes, whatever the requesters do meanwhile.
        if (pmem_resp) begin
          cmd_rd_d = 1'b0;
          cmd_wr_d = 1'b0;
          state_d  = IDLE;
        end
      end
      default: begin
        cmd_rd_d = 1'b0;
        cmd_wr_d = 1'b0;
        state_d  = IDLE;
      end
    endcase
  end

  // The command bits are cleared whenever the arbiter is IDLE, so they can drive pmem directly.
  assign pmem_read    = cmd_rd_q;
  assign pmem_write   = cmd_wr_q;
  assign pmem_address = cmd_addr_q;
  assign pmem_wdata   = cmd_wdata_q;

  assign i_mem_resp = (state_q == SERVE_I) & pmem_resp;
  assign d_mem_resp = (state_q == SERVE_D) & pmem_resp;

  // Read data passes straight through; each cache qualifies it with its own resp.
  assign i_mem_rdata = pmem_rdata;
  assign d_mem_rdata = pmem_rdata;

endmodule
